// File: rtl/display_pkg.sv
// Shared definitions for the display write path.
//   BASE_ADDR_DEF / WORDS_DEF / CTRL_ADDR_DEF / FIFO_DEPTH_DEF : default geometry
//   tex_wr_t     : pending write entry {is_fill, idx, data}
//   fill_state_t : commit engine states
package display_pkg;

   localparam logic [31:0] BASE_ADDR_DEF  = 32'h0000_1000;
   localparam int unsigned WORDS_DEF      = 2240;
   localparam logic [31:0] CTRL_ADDR_DEF  = 32'h0000_3300;
   localparam int unsigned FIFO_DEPTH_DEF = 4;

   typedef struct packed {
      logic        is_fill;
      logic [11:0] idx;
      logic [31:0] data;
   } tex_wr_t;

   typedef enum logic {
      IDLE,
      FILL
   } fill_state_t;

endpackage

// File: rtl/tex_wr_fifo.sv
// Synchronous FIFO of pending tex writes.
//   clk, rst_n : clock, async active-low reset (clears pointers and count)
//   push, din  : write request and entry; ignored while full
//   pop, dout  : read request and head entry; ignored while empty
//   full, empty: registered occupancy flags
module tex_wr_fifo
   import display_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push,
   input  tex_wr_t din,
   input  logic    pop,
   output tex_wr_t dout,
   output logic    full,
   output logic    empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   tex_wr_t        mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   // Push is judged against the registered count, so a push while full is
   // rejected even if a pop frees a slot on the same edge.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tex_write_bridge.sv
// Snoops core stores, queues those hitting the display window or the fill
// command register, and commits them in order into the registered tex array.
//   clk, rst_n : clock, async active-low reset
//   mem_we, mem_addr, mem_wdata : core data-memory write port (snooped)
//   stall : FIFO full, core must hold its store
//   busy  : fill running or writes pending
//   tex   : WORDS x 32-bit display array for the VGA stage
module tex_write_bridge
   import display_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
   parameter int unsigned WORDS      = WORDS_DEF,
   parameter logic [31:0] CTRL_ADDR  = CTRL_ADDR_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        stall,
   output logic        busy,
   output logic [31:0] tex [WORDS-1:0]
);

   localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(4 * WORDS);

   logic        data_hit;
   logic        ctrl_hit;
   logic [11:0] hit_idx;
   tex_wr_t     fifo_din;
   tex_wr_t     fifo_dout;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_pop;

   fill_state_t state, state_nxt;
   logic [11:0] ptr, ptr_nxt;
   logic [31:0] fill_val, fill_val_nxt;
   logic        wr_en;
   logic [11:0] wr_idx;
   logic [31:0] wr_data;

   // ---------------- decode ----------------
   assign data_hit = mem_we && (mem_addr[1:0] == 2'b00) &&
                     (mem_addr >= BASE_ADDR) && (mem_addr < END_ADDR);
   assign ctrl_hit = mem_we && (mem_addr == CTRL_ADDR);
   assign hit_idx  = 12'((mem_addr - BASE_ADDR) >> 2);

   always_comb begin
      fifo_din.is_fill = ctrl_hit;
      fifo_din.idx     = ctrl_hit ? 12'd0 : hit_idx;
      fifo_din.data    = mem_wdata;
   end

   tex_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (data_hit | ctrl_hit),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign stall = fifo_full;
   assign busy  = (state == FILL) | ~fifo_empty;

   // ---------------- commit engine ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         fill_val <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         fill_val <= fill_val_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      fill_val_nxt = fill_val;
      fifo_pop     = 1'b0;
      wr_en        = 1'b0;
      wr_idx       = '0;
      wr_data      = '0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (fifo_dout.is_fill) begin
                  // Fill entry only arms the engine; first write is next edge.
                  fill_val_nxt = fifo_dout.data;
                  ptr_nxt      = '0;
                  state_nxt    = FILL;
               end else begin
                  wr_en   = 1'b1;
                  wr_idx  = fifo_dout.idx;
                  wr_data = fifo_dout.data;
               end
            end
         end
         FILL: begin
            wr_en   = 1'b1;
            wr_idx  = ptr;
            wr_data = fill_val;
            if (ptr == 12'(WORDS - 1)) begin
               ptr_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               ptr_nxt = ptr + 12'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- display array ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < WORDS; i++) tex[i] <= '0;
      end else if (wr_en) begin
         tex[wr_idx] <= wr_data;
      end
   end

endmodule
